// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Handles redirects, load-use stalls, bubbles, self-loop halt and bad-PC flags.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid,
  output logic        halted,
  output logic        range_err,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc4, npc;
  logic        bad_pc, halt_hit;

  assign pc4 = pc + 32'd4;

  always_comb begin
    npc = pc4;
    case (pcsrc)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      default: npc = jpc;
    endcase
  end

  // Anything beyond the ROM word range, or not word aligned, is flagged.
  assign bad_pc = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);

  // A jump in ID whose target is its own address is a self-loop.
  assign halt_hit = dvalid && (pcsrc == 2'b11) && (jpc == dpc4 - 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      dpc4      <= '0;
      dinst     <= '0;
      dvalid    <= 1'b0;
      halted    <= 1'b0;
      range_err <= 1'b0;
      fetch_cnt <= '0;
    end else if (halted) begin
      dinst  <= '0;
      dvalid <= 1'b0;
    end else if (!stall) begin
      pc   <= npc;
      dpc4 <= pc4;
      if (halt_hit) halted    <= 1'b1;
      if (bad_pc)   range_err <= 1'b1;
      if (flush) begin
        dinst  <= '0;
        dvalid <= 1'b0;
      end else begin
        dinst     <= imem_inst;
        dvalid    <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: per-edge stimulus rows carry the expected IF state,
// which is queued when the row is driven and compared after the edge.
module tb_if_stage_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        stall, flush;
  logic [31:0] imem_inst;
  logic [31:0] pc, dpc4, dinst, fetch_cnt;
  logic        dvalid, halted, range_err;

  if_stage_fetch #(.RESET_PC(32'h0), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .stall(stall), .flush(flush), .imem_inst(imem_inst),
    .pc(pc), .dpc4(dpc4), .dinst(dinst), .dvalid(dvalid),
    .halted(halted), .range_err(range_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic        halted;
    logic        range_err;
    logic [31:0] fetch_cnt;
  } st_t;

  typedef struct packed {
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        stall;
    logic        flush;
    logic [31:0] imem;
    st_t         exp;
  } row_t;

  row_t stim_q[$];
  st_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic [1:0] sel, input logic [31:0] b,
                     input logic [31:0] rr, input logic [31:0] j, input logic s,
                     input logic f, input logic [31:0] im, input logic [31:0] e_pc,
                     input logic [31:0] e_dpc4, input logic [31:0] e_inst, input logic e_v,
                     input logic e_h, input logic e_re, input logic [31:0] e_cnt);
    row_t w;
    w.rst = r; w.pcsrc = sel; w.bpc = b; w.rpc = rr; w.jpc = j;
    w.stall = s; w.flush = f; w.imem = im;
    w.exp = '{pc: e_pc, dpc4: e_dpc4, dinst: e_inst, dvalid: e_v,
              halted: e_h, range_err: e_re, fetch_cnt: e_cnt};
    stim_q.push_back(w);
  endtask

  // Drives one row's inputs and queues its expected post-edge state.
  task automatic drive(input row_t w);
    rst = w.rst; pcsrc = w.pcsrc; bpc = w.bpc; rpc = w.rpc; jpc = w.jpc;
    stall = w.stall; flush = w.flush; imem_inst = w.imem;
    exp_q.push_back(w.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic st_t snap();
    return '{pc: pc, dpc4: dpc4, dinst: dinst, dvalid: dvalid,
             halted: halted, range_err: range_err, fetch_cnt: fetch_cnt};
  endfunction

  task automatic test_reset();
    st_t g, e;
    int  k = 0;
    add(1, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2'b11, 32'h80, 32'h90, 32'ha0, 1, 1, 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_sequential();
    st_t g, e;
    int  k = 0;
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h3c010000, 32'h04, 32'h04, 32'h3c010000, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h34240050, 32'h08, 32'h08, 32'h34240050, 1, 0, 0, 2);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h0c00001b, 32'h0c, 32'h0c, 32'h0c00001b, 1, 0, 0, 3);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL sequential[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_jump_delay_slot();
    st_t g, e;
    int  k = 0;
    add(0, 2'b11, 32'h80, 32'h90, 32'h6c, 0, 0, 32'h20050004, 32'h6c, 32'h10, 32'h20050004, 1, 0, 0, 4);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL jump[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    st_t g, e;
    int  k = 0;
    add(0, 2'b10, 32'h80, 32'h14, 32'ha0, 0, 0, 32'h11111111, 32'h14, 32'h70, 32'h11111111, 1, 0, 0, 5);
    add(0, 2'b01, 32'h50, 32'h90, 32'ha0, 1, 0, 32'h22222222, 32'h14, 32'h70, 32'h11111111, 1, 0, 0, 5);
    add(0, 2'b01, 32'h50, 32'h90, 32'ha0, 1, 1, 32'h22222222, 32'h14, 32'h70, 32'h11111111, 1, 0, 0, 5);
    add(0, 2'b01, 32'h50, 32'h90, 32'ha0, 0, 1, 32'h22222222, 32'h50, 32'h18, 32'h00000000, 0, 0, 0, 5);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stall_flush[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_halt();
    st_t g, e;
    int  k = 0;
    add(0, 2'b11, 32'h80, 32'h90, 32'h64, 0, 0, 32'h33333333, 32'h64, 32'h54, 32'h33333333, 1, 0, 0, 6);
    add(0, 2'b00, 32'h80, 32'h90, 32'h64, 0, 0, 32'h08000019, 32'h68, 32'h68, 32'h08000019, 1, 0, 0, 7);
    add(0, 2'b11, 32'h80, 32'h90, 32'h64, 0, 0, 32'h24020001, 32'h64, 32'h6c, 32'h24020001, 1, 1, 0, 8);
    add(0, 2'b11, 32'h80, 32'h90, 32'h64, 0, 0, 32'h44444444, 32'h64, 32'h6c, 32'h00000000, 0, 1, 0, 8);
    add(0, 2'b00, 32'h80, 32'h90, 32'h64, 0, 0, 32'h44444444, 32'h64, 32'h6c, 32'h00000000, 0, 1, 0, 8);
    add(0, 2'b01, 32'h50, 32'h90, 32'h64, 1, 0, 32'h44444444, 32'h64, 32'h6c, 32'h00000000, 0, 1, 0, 8);
    add(1, 2'b00, 32'h80, 32'h90, 32'h64, 0, 0, 32'h44444444, 32'h00, 32'h00, 32'h00000000, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL halt[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_range_error();
    st_t g, e;
    int  k = 0;
    add(0, 2'b10, 32'h80, 32'h102, 32'ha0, 0, 0, 32'h55555555, 32'h102, 32'h04, 32'h55555555, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h66666666, 32'h106, 32'h106, 32'h66666666, 1, 0, 1, 2);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h77777777, 32'h10a, 32'h10a, 32'h77777777, 1, 0, 1, 3);
    add(1, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h77777777, 32'h00, 32'h00, 32'h00000000, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL range_err[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  task automatic test_boundary();
    st_t g, e;
    int  k = 0;
    // Last legal word, then the first word past the ROM.
    add(0, 2'b10, 32'h80, 32'hfc, 32'ha0, 0, 0, 32'h1, 32'hfc, 32'h04, 32'h1, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h2, 32'h100, 32'h100, 32'h2, 1, 0, 0, 2);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h3, 32'h104, 32'h104, 32'h3, 1, 0, 1, 3);
    add(1, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h3, 32'h00, 32'h00, 32'h0, 0, 0, 0, 0);
    // Misaligned only; a stalled edge must not flag it.
    add(0, 2'b10, 32'h80, 32'h02, 32'ha0, 0, 0, 32'h4, 32'h02, 32'h04, 32'h4, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 1, 0, 32'h5, 32'h02, 32'h04, 32'h4, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h5, 32'h06, 32'h06, 32'h5, 1, 0, 1, 2);
    add(1, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h5, 32'h00, 32'h00, 32'h0, 0, 0, 0, 0);
    // pc+4 wrap, then a self-loop jump detected on a flush edge.
    add(0, 2'b10, 32'h80, 32'hfffffffc, 32'ha0, 0, 0, 32'h6, 32'hfffffffc, 32'h04, 32'h6, 1, 0, 0, 1);
    add(0, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h7, 32'h00, 32'h00, 32'h7, 1, 0, 1, 2);
    add(0, 2'b11, 32'h80, 32'h90, 32'hfffffffc, 0, 1, 32'h8, 32'hfffffffc, 32'h04, 32'h0, 0, 1, 1, 2);
    add(1, 2'b00, 32'h80, 32'h90, 32'ha0, 0, 0, 32'h8, 32'h00, 32'h00, 32'h0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front()); tick();
      g = snap(); e = exp_q.pop_front(); n_tests++; k++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL boundary[%0d] got=%h expected=%h", k, g, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pcsrc = 2'b00; bpc = '0; rpc = '0; jpc = '0;
    stall = 1'b0; flush = 1'b0; imem_inst = '0;
    #2;
    test_reset();
    test_sequential();
    test_jump_delay_slot();
    test_stall_flush();
    test_halt();
    test_range_error();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the pipelined CPU; the requesting end of the instruction ROM interface.
- Holds the PC, drives it as the ROM word address, and selects the next PC from the ID-stage redirect inputs.
- Owns the IF/ID pipeline register, with stall, bubble, halt and range-error handling.
- MIPS branch delay slot semantics: the instruction after a branch or jump is always fetched and passed on unless explicitly flushed.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ADDR_W, 6, ROM word-index width; legal fetch range is 0 .. 4*2^ADDR_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- pcsrc  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
- bpc  in  32  branch target
- rpc  in  32  register (jr) target
- jpc  in  32  jump target
- stall  in  1  load-use hazard; freezes PC and IF/ID
- flush  in  1  inserts a bubble into IF/ID on this advance
- imem_inst  in  32  instruction word returned by ROM for address pc (combinational, same cycle)
- pc  out  32  current fetch address to ROM
- dpc4  out  32  IF/ID: pc+4 of the latched instruction
- dinst  out  32  IF/ID: latched instruction
- dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble
- halted  out  1  sticky: self-loop jump detected
- range_err  out  1  sticky: a misaligned or out-of-range PC was fetched
- fetch_cnt  out  32  number of real instructions latched into IF/ID

Behaviour:
- Reset (rst=1 at a clk edge) sets: pc=RESET_PC, dpc4=0, dinst=0, dvalid=0, halted=0, range_err=0, fetch_cnt=0. Reset overrides every other input, including mid-stall and after halt.
- pc4 = pc+4, modulo 2^32.
- npc is combinational: pcsrc 00 gives pc4, 01 gives bpc, 10 gives rpc, 11 gives jpc. Targets are loaded verbatim, with no masking.
- Per-edge priority, highest first: rst, halted, stall, flush, normal.
- Halted (halted=1): pc holds, dpc4 holds, dinst<=0, dvalid<=0, fetch_cnt holds. The delay slot therefore executes exactly once before bubbles are issued.
- Stall (stall=1): pc, dpc4, dinst, dvalid and fetch_cnt all hold. pcsrc and flush are ignored; the ID instruction re-issues its redirect next cycle.
- Flush (flush=1, no stall): pc<=npc, dpc4<=pc4, dinst<=0, dvalid<=0, fetch_cnt holds.
- Normal: pc<=npc, dpc4<=pc4, dinst<=imem_inst, dvalid<=1, fetch_cnt<=fetch_cnt+1 (wraps 0xFFFFFFFF to 0).
- Halt detection: on a non-stalled, non-halted edge, halted<=1 when all of the following hold:
  - dvalid=1,
  - pcsrc=11,
  - jpc==dpc4-4.
  - The same edge still performs its flush or normal update; halting takes effect from the next edge.
- Range-error detection: on a flush or normal edge, range_err<=1 when either pc[1:0]!=0 or pc[31:ADDR_W+2]!=0.
  - The bad word is still latched; the ROM aliases it.
  - Sticky until reset.
- Latency: an instruction fetched at pc appears on dinst one edge later. A redirect presented while the branch is in ID takes effect at the next edge, and the delay slot (already at pc) is latched on that same edge.
- pc is registered only; no combinational path exists from inputs to pc.

Test Plan:
- Reset: rst=1 for 2 edges, then release -> pc=0, dinst=0, dvalid=0, fetch_cnt=0, halted=0, range_err=0.
- Sequential fetch: pcsrc=00, ROM returns 3c010000, 34240050, 0c00001b over 3 edges -> after each edge pc=04, 08, 0c; dinst follows the sequence with dpc4=04, 08, 0c; fetch_cnt=3.
- Jump with delay slot: dinst=0c00001b, dpc4=0c, pc=0c, imem_inst=20050004, pcsrc=11, jpc=6c -> pc=6c, dinst=20050004, dvalid=1, halted stays 0.
- Stall then flush:
  - At pc=14, stall=1 for 2 edges with pcsrc=01, bpc=50 -> pc=14 and dinst/fetch_cnt unchanged.
  - Then stall=0, flush=1 -> pc=50, dinst=0, dvalid=0, fetch_cnt unchanged.
- Halt: dinst=08000019, dpc4=68, pc=68, imem_inst=0, pcsrc=11, jpc=64.
  - Edge 1: pc=64, dvalid=1, halted=1.
  - Following 3 edges: pc=64, dvalid=0, fetch_cnt frozen.
  - Then rst=1 -> halted=0, pc=0.
- Range error: pcsrc=10, rpc=00000102 -> next edge pc=102, range_err=0; following edge range_err=1, and it stays 1 after pcsrc returns to 00.
